// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the 8-bit accumulator ALU datapath: owns the accumulator and steps each op through the ALU.
// Optional build macro ALU_SEQ_SAT_EN saturates overflowing results to 8'hFF instead of entering S_run_error.
module alu_seq_ctrl #(
  parameter int ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_operand,
  output logic [7:0] num1,
  output logic [7:0] num2,
  output logic [2:0] in_selector,
  output logic [6:0] out_selector,
  input  logic [7:0] alu_result,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_error,
  input  logic       err_clr,
  output logic [1:0] state
);

  localparam logic [1:0] S_off       = 2'b00;
  localparam logic [1:0] S_ready     = 2'b01;
  localparam logic [1:0] S_run       = 2'b10;
  localparam logic [1:0] S_run_error = 2'b11;

  localparam logic [2:0] OP_LOAD  = 3'd7;
  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

  logic [7:0] acc;
  logic [3:0] latCnt;
  logic       issue;
  logic [6:0] opOneHot;

  // Op code 0 (AND) maps to the MSB of the output-mux select, op 6 (MULT) to the LSB.
  always_comb begin
    opOneHot = 7'b1000000 >> cmd_op;
  end

  always_comb begin
    if (state == S_off)
      in_selector = 3'b001;
    else if (issue)
      in_selector = 3'b010;
    else
      in_selector = 3'b100;
  end

  assign cmd_ready = (state == S_ready) && !rsp_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_off;
      acc          <= 8'h00;
      num1         <= 8'h00;
      num2         <= 8'h00;
      out_selector <= 7'b0000000;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      rsp_error    <= 1'b0;
      latCnt       <= 4'd0;
      issue        <= 1'b0;
    end else if (!on) begin
      // Power-down aborts any operation and drops a pending response; acc survives.
      state     <= S_off;
      rsp_valid <= 1'b0;
      issue     <= 1'b0;
    end else begin
      issue <= 1'b0;
      case (state)
        S_off: state <= S_ready;
        S_ready: begin
          if (rsp_valid) begin
            if (rsp_ready) rsp_valid <= 1'b0;
          end else if (cmd_valid) begin
            if (cmd_op == OP_LOAD) begin
              acc       <= cmd_operand;
              rsp_data  <= cmd_operand;
              rsp_error <= 1'b0;
              rsp_valid <= 1'b1;
            end else begin
              num1         <= acc;
              num2         <= cmd_operand;
              out_selector <= opOneHot;
              latCnt       <= LAT_INIT;
              issue        <= 1'b1;
              state        <= S_run;
            end
          end
        end
        S_run: begin
          if (rsp_valid) begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              state     <= S_ready;
            end
          end else if (latCnt != 4'd0) begin
            latCnt <= latCnt - 4'd1;
          end else begin
            rsp_valid <= 1'b1;
`ifdef ALU_SEQ_SAT_EN
            rsp_error <= 1'b0;
            if (alu_overflow) begin
              acc      <= 8'hFF;
              rsp_data <= 8'hFF;
            end else begin
              acc      <= alu_result;
              rsp_data <= alu_result;
            end
`else
            rsp_data <= alu_result;
            if (alu_overflow) begin
              rsp_error <= 1'b1;
              state     <= S_run_error;
            end else begin
              acc       <= alu_result;
              rsp_error <= 1'b0;
            end
`endif
          end
        end
        S_run_error: begin
          // The error response must drain before err_clr can release the FSM.
          if (rsp_valid) begin
            if (rsp_ready) rsp_valid <= 1'b0;
          end else if (err_clr) begin
            state <= S_ready;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small pipelined ALU stand-in of depth ALU_LAT.
// Honours ALU_SEQ_SAT_EN for the overflow scenario.
module tb_alu_seq_ctrl;

  localparam int ALU_LAT = 2;

  logic       clk;
  logic       rst;
  logic       on;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_operand;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [2:0] in_selector;
  logic [6:0] out_selector;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_error;
  logic       err_clr;
  logic [1:0] state;

  int assertCount = 0;
  int failCount   = 0;

  alu_seq_ctrl #(.ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .on(on),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .num1(num1), .num2(num2),
    .in_selector(in_selector), .out_selector(out_selector),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_error(rsp_error),
    .err_clr(err_clr), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  modelRes;
  logic        modelOvf;
  logic [15:0] modelProd;

  always_comb begin
    modelProd = 16'(num1) * 16'(num2);
    modelRes  = 8'h00;
    modelOvf  = 1'b0;
    case (out_selector)
      7'b1000000: modelRes = num1 & num2;
      7'b0100000: modelRes = num1 | num2;
      7'b0010000: modelRes = ~num1;
      7'b0001000: modelRes = num1 ^ num2;
      7'b0000100: {modelOvf, modelRes} = {1'b0, num1} + {1'b0, num2};
      7'b0000010: begin
        modelRes = num1 - num2;
        modelOvf = num1 < num2;
      end
      7'b0000001: begin
        modelRes = modelProd[7:0];
        modelOvf = |modelProd[15:8];
      end
      default: ;
    endcase
  end

  // Only the issue cycle launches a real result; other slots carry junk so early capture is visible.
  logic [8:0] aluPipe [ALU_LAT];
  always @(posedge clk) begin
    aluPipe[0] <= (in_selector == 3'b010) ? {modelOvf, modelRes} : 9'h05A;
    for (int i = 1; i < ALU_LAT; i++) aluPipe[i] <= aluPipe[i-1];
  end
  assign alu_result   = aluPipe[ALU_LAT-1][7:0];
  assign alu_overflow = aluPipe[ALU_LAT-1][8];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] val);
    cmd_op      = op;
    cmd_operand = val;
    checkOutput("cmdReadyBeforeAccept", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "State"},    32'(state),        32'h0);
    checkOutput({tag, "CmdReady"}, 32'(cmd_ready),    32'h0);
    checkOutput({tag, "RspValid"}, 32'(rsp_valid),    32'h0);
    checkOutput({tag, "RspError"}, 32'(rsp_error),    32'h0);
    checkOutput({tag, "RspData"},  32'(rsp_data),     32'h0);
    checkOutput({tag, "Num1"},     32'(num1),         32'h0);
    checkOutput({tag, "Num2"},     32'(num2),         32'h0);
    checkOutput({tag, "InSel"},    32'(in_selector),  32'h1);
    checkOutput({tag, "OutSel"},   32'(out_selector), 32'h0);
  endtask

  // Runs a non-LOAD op end to end against hand-computed values, acknowledging immediately.
  task automatic runOp(input string tag, input logic [2:0] op, input logic [7:0] val,
                       input logic [7:0] expNum1, input logic [6:0] expSel, input logic [7:0] expData);
    int lat;
    applyStimulus(op, val);
    checkOutput({tag, "Num1"},   32'(num1),         32'(expNum1));
    checkOutput({tag, "OutSel"}, 32'(out_selector), 32'(expSel));
    waitRsp(1, lat);
    checkOutput({tag, "Latency"}, 32'(lat),       32'd4);
    checkOutput({tag, "Data"},    32'(rsp_data),  32'(expData));
    checkOutput({tag, "Error"},   32'(rsp_error), 32'd0);
    tick();
    checkOutput({tag, "ReadyAfter"}, 32'(cmd_ready), 32'd1);
  endtask

  logic [7:0] expAcc;
  logic [7:0] expData;
  logic       seenRsp;
  int         lat;

  initial begin
    rst = 1'b0; on = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_operand = 8'h00;
    rsp_ready = 1'b1; err_clr = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    checkResetValues("reset");

    on = 1'b1;
    tick();
    checkOutput("onState",    32'(state),       32'h1);
    checkOutput("onCmdReady", 32'(cmd_ready),   32'h1);
    checkOutput("onInSel",    32'(in_selector), 32'h4);

    applyStimulus(3'd7, 8'h05);
    checkOutput("loadRspValid", 32'(rsp_valid), 32'h1);
    checkOutput("loadRspData",  32'(rsp_data),  32'h05);
    checkOutput("loadRspError", 32'(rsp_error), 32'h0);
    checkOutput("loadCmdReady", 32'(cmd_ready), 32'h0);
    tick();
    checkOutput("loadDone", 32'(rsp_valid), 32'h0);

    applyStimulus(3'd4, 8'h03);
    checkOutput("addState",  32'(state),        32'h2);
    checkOutput("addIssue",  32'(in_selector),  32'h2);
    checkOutput("addOutSel", 32'(out_selector), 32'h04);
    checkOutput("addNum1",   32'(num1),         32'h05);
    checkOutput("addNum2",   32'(num2),         32'h03);
    tick();
    checkOutput("addPostIssueInSel",  32'(in_selector),  32'h4);
    checkOutput("addPostIssueOutSel", 32'(out_selector), 32'h04);
    waitRsp(2, lat);
    checkOutput("addLatency", 32'(lat),       32'd4);
    checkOutput("addRspData", 32'(rsp_data),  32'h08);
    checkOutput("addRspErr",  32'(rsp_error), 32'h0);
    tick();
    checkOutput("addBackToReady", 32'(state),     32'h1);
    checkOutput("addCmdReady",    32'(cmd_ready), 32'h1);
    expAcc = 8'h08;

    rsp_ready = 1'b0;
    applyStimulus(3'd6, 8'h40);
    checkOutput("multNum1",   32'(num1),         32'(expAcc));
    checkOutput("multOutSel", 32'(out_selector), 32'h01);
    waitRsp(1, lat);
    checkOutput("multLatency", 32'(lat), 32'd4);
`ifdef ALU_SEQ_SAT_EN
    expData = 8'hFF;
    checkOutput("satRspData",  32'(rsp_data),  32'hFF);
    checkOutput("satRspError", 32'(rsp_error), 32'h0);
    checkOutput("satState",    32'(state),     32'h2);
`else
    expData = 8'h00;
    checkOutput("ovfRspData",  32'(rsp_data),  32'h00);
    checkOutput("ovfRspError", 32'(rsp_error), 32'h1);
    checkOutput("ovfState",    32'(state),     32'h3);
    checkOutput("ovfCmdReady", 32'(cmd_ready), 32'h0);
`endif

    cmd_op = 3'd7; cmd_operand = 8'h77; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stallValid",    32'(rsp_valid), 32'h1);
      checkOutput("stallData",     32'(rsp_data),  32'(expData));
      checkOutput("stallCmdReady", 32'(cmd_ready), 32'h0);
    end
    cmd_valid = 1'b0;

`ifdef ALU_SEQ_SAT_EN
    rsp_ready = 1'b1;
    tick();
    checkOutput("satDrained", 32'(rsp_valid), 32'h0);
    checkOutput("satReady",   32'(state),     32'h1);
    expAcc = 8'hFF;
`else
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("errClrWhilePending", 32'(state), 32'h3);
    rsp_ready = 1'b1;
    tick();
    checkOutput("errDrained",      32'(rsp_valid), 32'h0);
    checkOutput("errStillLatched", 32'(state),     32'h3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("errCleared", 32'(state), 32'h1);
`endif
    checkOutput("postOvfCmdReady", 32'(cmd_ready), 32'h1);

    runOp("andAcc", 3'd0, 8'hFF, expAcc, 7'b1000000, expAcc);

    applyStimulus(3'd1, 8'h0F);
    checkOutput("orRunState", 32'(state), 32'h2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkResetValues("midReset");
    tick();
    checkOutput("midResetReady", 32'(state), 32'h1);

    applyStimulus(3'd7, 8'h3C);
    checkOutput("load3cData", 32'(rsp_data), 32'h3C);
    tick();

    applyStimulus(3'd5, 8'h0C);
    checkOutput("subRunState", 32'(state),        32'h2);
    checkOutput("subOutSel",   32'(out_selector), 32'h02);
    on = 1'b0;
    tick();
    checkOutput("abortState",    32'(state),       32'h0);
    checkOutput("abortRspValid", 32'(rsp_valid),   32'h0);
    checkOutput("abortInSel",    32'(in_selector), 32'h1);
    on = 1'b1;
    seenRsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seenRsp = seenRsp | rsp_valid;
    end
    checkOutput("abortNoRsp", 32'(seenRsp), 32'h0);
    checkOutput("abortReady", 32'(state),   32'h1);

    runOp("andRetained", 3'd0, 8'hFF, 8'h3C, 7'b1000000, 8'h3C);
    runOp("xor",         3'd3, 8'h0F, 8'h3C, 7'b0001000, 8'h33);
    runOp("not",         3'd2, 8'hA0, 8'h33, 7'b0010000, 8'hCC);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
